// File: rtl/valid_grant_scheduler.sv
// valid_grant_scheduler: snapshots a request vector on start and grants
// each flagged requester once, round-robin, waiting for ack per grant.
//
// Parameters: N requesters, IW = clog2(N) index width,
//   CW = clog2(N)+1 count width, TIMEOUT ack wait limit in cycles.
// Ports:
//   clk, rst       clock (rising edge), async active-high reset
//   start          begin a run (sampled only when idle)
//   valids [N]     request vector, captured on accepted start
//   ack            current grant served (ignored unless grant_vld)
//   grant [N]      one-hot grant, 0 when grant_vld=0
//   grant_idx [IW] granted index, 0 when grant_vld=0
//   grant_vld      grant outputs valid
//   remaining [CW] requesters still pending in this run
//   busy           high in every state except idle
//   done           one-cycle pulse at the end of a run
//   err_drop       one-cycle pulse when a grant is dropped on timeout
// Option: define SCHED_TIMEOUT_EN to drop a grant after TIMEOUT cycles
//   without ack; otherwise the wait is unbounded and err_drop is 0.
module valid_grant_scheduler #(
  parameter int N       = 16,
  parameter int IW      = 4,
  parameter int CW      = 5,
  parameter int TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  valids,
  input  logic          ack,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld,
  output logic [CW-1:0] remaining,
  output logic          busy,
  output logic          done,
  output logic          err_drop
);

  if (IW != $clog2(N) || CW != $clog2(N) + 1 || TIMEOUT < 1)
  begin : g_bad_cfg
    $error("valid_grant_scheduler: inconsistent parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [N-1:0]  pend_q;
  logic [IW-1:0] ptr_q;
  logic [N-1:0]  grant_q;
  logic [IW-1:0] idx_q;
  logic          vld_q;
  logic [CW-1:0] rem_q;

  logic [CW-1:0] pop;
  logic [N-1:0]  above;
  logic [N-1:0]  src;
  logic [IW-1:0] pick;
  logic [IW-1:0] ptr_d;
  logic          to_hit;
  logic          retire;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + CW'(valids[i]);
    end
  end

  // Search at or above ptr first; wrap to the
  // whole pending set only if nothing is there.
  always_comb begin
    above = '0;
    for (int i = 0; i < N; i++) begin
      above[i] = pend_q[i] && (IW'(i) >= ptr_q);
    end
  end

  assign src = (|above) ? above : pend_q;

  always_comb begin
    pick = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (src[i]) begin
        pick = IW'(i);
      end
    end
  end

  assign ptr_d = (idx_q == IW'(N - 1)) ? '0
                                       : idx_q + 1'b1;

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wcnt_q;
  logic          err_q;

  assign to_hit   = (wcnt_q == TW'(TIMEOUT - 1));
  assign err_drop = err_q;
`else
  assign to_hit   = 1'b0;
  assign err_drop = 1'b0;
`endif

  // A timeout drop retires the grant exactly like an ack.
  assign retire = vld_q && (ack || to_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      rem_q   <= '0;
`ifdef SCHED_TIMEOUT_EN
      wcnt_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
`ifdef SCHED_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            pend_q  <= valids;
            rem_q   <= pop;
            state_q <= (pop != '0) ? S_GRANT : S_DONE;
          end
        end
        S_GRANT: begin
          grant_q       <= '0;
          grant_q[pick] <= 1'b1;
          idx_q         <= pick;
          vld_q         <= 1'b1;
`ifdef SCHED_TIMEOUT_EN
          wcnt_q        <= '0;
`endif
          state_q       <= S_WAIT;
        end
        S_WAIT: begin
          if (retire) begin
            pend_q[idx_q] <= 1'b0;
            if (rem_q != '0) begin
              rem_q <= rem_q - CW'(1);
            end
            ptr_q   <= ptr_d;
            vld_q   <= 1'b0;
            grant_q <= '0;
            idx_q   <= '0;
            state_q <= (rem_q == CW'(1)) ? S_DONE
                                         : S_GRANT;
`ifdef SCHED_TIMEOUT_EN
            err_q   <= ~ack;
`endif
          end else begin
`ifdef SCHED_TIMEOUT_EN
            wcnt_q <= wcnt_q + TW'(1);
`endif
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign grant_vld = vld_q;
  assign remaining = rem_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_valid_grant_scheduler.sv
// tb_valid_grant_scheduler: directed bench for valid_grant_scheduler.
// Expected grant orders are written out by hand per run.
module tb_valid_grant_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] valids;
  logic        ack;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_vld;
  logic [4:0]  remaining;
  logic        busy;
  logic        done;
  logic        err_drop;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int exp_ord[16];

  valid_grant_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .valids    (valids),
    .ack       (ack),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .remaining (remaining),
    .busy      (busy),
    .done      (done),
    .err_drop  (err_drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gv(input string tag);
    int c;
    c = 0;
    while (grant_vld !== 1'b1 && c < 16) begin
      tick();
      c++;
    end
    chk({tag, "_gv"}, 32'(grant_vld), 1);
  endtask

  task automatic run(input string tag,
                     input logic [15:0] v,
                     input int n,
                     input bit rnd);
    int d0;
    int dly;
    d0 = done_cnt;
    start = 1'b1;
    valids = v;
    tick();
    start = 1'b0;
    valids = ~v;
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_rem0"}, 32'(remaining), n);
    if (n == 0) begin
      chk({tag, "_done0"}, 32'(done), 1);
      chk({tag, "_nogv"}, 32'(grant_vld), 0);
      chk({tag, "_nogr"}, 32'(grant), 0);
    end
    ack = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_gv(tag);
      ack = 1'b0;
      chk({tag, "_idx"}, 32'(grant_idx), exp_ord[k]);
      chk({tag, "_oh"}, 32'(grant), 32'(1) << exp_ord[k]);
      chk({tag, "_rem"}, 32'(remaining), n - k);
      dly = rnd ? int'($urandom_range(0, 5)) : 0;
      for (int j = 0; j < dly; j++) begin
        start = rnd;
        tick();
        start = 1'b0;
        chk({tag, "_hold"}, 32'(grant_idx), exp_ord[k]);
      end
      ack = 1'b1;
      start = rnd;
      tick();
      ack = 1'b0;
      start = 1'b0;
      chk({tag, "_gvlo"}, 32'(grant_vld), 0);
      chk({tag, "_remd"}, 32'(remaining), n - k - 1);
      chk({tag, "_dn"}, 32'(done), (k == n - 1) ? 1 : 0);
    end
    ack = 1'b0;
    tick();
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_npulse"}, done_cnt - d0, 1);
    valids = '0;
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    start = 1'b0;
    valids = '0;
    ack = 1'b0;
    tick();
    tick();
    chk("rst_gv", 32'(grant_vld), 0);
    chk("rst_gr", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rem", 32'(remaining), 0);
    chk("rst_err", 32'(err_drop), 0);
    rst = 1'b0;
    tick();

    run("t2", 16'h0000, 0, 1'b0);

    exp_ord[0] = 0;
    exp_ord[1] = 15;
    run("t3", 16'h8001, 2, 1'b0);

    exp_ord[0] = 4;
    run("t4a", 16'h0010, 1, 1'b0);
    exp_ord[0] = 5;
    exp_ord[1] = 0;
    run("t4b", 16'h0021, 2, 1'b0);

    for (int k = 0; k < 16; k++) exp_ord[k] = (k + 1) % 16;
    run("t5", 16'hFFFF, 16, 1'b1);

    // ptr is 1 here; reset mid-wait must clear it.
    d0 = done_cnt;
    start = 1'b1;
    valids = 16'h0003;
    tick();
    start = 1'b0;
    wait_gv("t1");
    chk("t1_ptr1", 32'(grant_idx), 1);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t1_gv", 32'(grant_vld), 0);
    chk("t1_gr", 32'(grant), 0);
    chk("t1_idx", 32'(grant_idx), 0);
    chk("t1_rem", 32'(remaining), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_done", 32'(done), 0);
    chk("t1_err", 32'(err_drop), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t1_idle", 32'(busy), 0);
    chk("t1_nodone", done_cnt - d0, 0);
    exp_ord[0] = 0;
    exp_ord[1] = 1;
    run("t1b", 16'h0003, 2, 1'b0);
    exp_ord[0] = 15;
    run("wrap", 16'h8000, 1, 1'b0);

    d0 = done_cnt;
    start = 1'b1;
    valids = 16'h0006;
    tick();
    start = 1'b0;
    valids = '0;
    wait_gv("t6");
    chk("t6_idx1", 32'(grant_idx), 1);
    chk("t6_rem2", 32'(remaining), 2);
`ifdef SCHED_TIMEOUT_EN
    for (int j = 0; j < 7; j++) begin
      tick();
      chk("t6_wait", 32'(grant_vld), 1);
      chk("t6_err0", 32'(err_drop), 0);
    end
    tick();
    chk("t6_err", 32'(err_drop), 1);
    chk("t6_drop", 32'(grant_vld), 0);
    chk("t6_rem1", 32'(remaining), 1);
    tick();
    chk("t6_errlo", 32'(err_drop), 0);
`else
    for (int j = 0; j < 12; j++) begin
      tick();
      chk("t6_wait", 32'(grant_vld), 1);
      chk("t6_held", 32'(grant_idx), 1);
      chk("t6_err0", 32'(err_drop), 0);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t6_drop", 32'(grant_vld), 0);
    chk("t6_rem1", 32'(remaining), 1);
`endif
    wait_gv("t6b");
    chk("t6_idx2", 32'(grant_idx), 2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t6_done", 32'(done), 1);
    chk("t6_rem0", 32'(remaining), 0);
    tick();
    chk("t6_idle", 32'(busy), 0);
    chk("t6_npulse", done_cnt - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
